// File: rtl/mcpu_ram_pkg.sv
// Shared constants and state encoding for the MCPU RAM arbiter/controller.
package mcpu_ram_pkg;

    localparam int DEF_WORD_SIZE    = 16;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/mcpu_ram_array.sv
// Single-port synchronous RAM with a registered read port (read-before-write).
module mcpu_ram_array #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_SIZE-1:0]  wdata,
    output logic [WORD_SIZE-1:0]  rdata
);

    localparam int RAM_SIZE = 2 ** ADDR_WIDTH;

    logic [WORD_SIZE-1:0] r_mem [RAM_SIZE];

    // Array write and registered read on every edge
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/mcpu_ram_arbctrl.sv
// Clocked RAM controller sharing one single-port array between the MCPU data
// and instruction-fetch ports, with starvation guard and post-reset clear.
module mcpu_ram_arbctrl
    import mcpu_ram_pkg::*;
#(
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WORD_SIZE-1:0]  d_rdata,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [WORD_SIZE-1:0]  i_rdata,
    output logic                  busy
);

    localparam int RAM_SIZE = 2 ** ADDR_WIDTH;
    localparam int CW       = ADDR_WIDTH + 1;
    localparam int SW       = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] CLR_LAST   = CW'(RAM_SIZE - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam state_t        RST_STATE  = (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;

    state_t                r_state;
    logic [CW-1:0]         r_clr_cnt;
    logic [SW-1:0]         r_starve;
    logic                  r_d_rvalid;
    logic                  r_i_rvalid;
    logic [WORD_SIZE-1:0]  r_d_hold;
    logic [WORD_SIZE-1:0]  r_i_hold;

    logic                  w_run;
    logic                  w_clearing;
    logic                  w_i_win;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WORD_SIZE-1:0]  w_wdata;
    logic [WORD_SIZE-1:0]  w_mem_rdata;
    logic                  w_d_rv;
    logic                  w_i_rv;

    assign w_run      = (r_state == S_RUN) && !rst;
    assign w_clearing = (r_state == S_CLEAR) && !rst;
    assign w_i_win    = i_req && (!d_req || (r_starve == STARVE_MAX));
    assign d_gnt      = w_run && d_req && !w_i_win;
    assign i_gnt      = w_run && w_i_win;
    assign busy       = (r_state == S_CLEAR);

    // A read granted just before reset must not surface as a valid response
    assign w_d_rv     = r_d_rvalid && !rst;
    assign w_i_rv     = r_i_rvalid && !rst;
    assign d_rvalid   = w_d_rv;
    assign i_rvalid   = w_i_rv;
    assign d_rdata    = w_d_rv ? w_mem_rdata : r_d_hold;
    assign i_rdata    = w_i_rv ? w_mem_rdata : r_i_hold;

    // Array port steering: clear walker, then the granted requester
    always_comb begin
        w_we    = 1'b0;
        w_addr  = d_addr;
        w_wdata = d_wdata;
        if (w_clearing) begin
            w_we    = 1'b1;
            w_addr  = r_clr_cnt[ADDR_WIDTH-1:0];
            w_wdata = '0;
        end else if (i_gnt) begin
            w_addr  = i_addr;
        end else begin
            w_we    = d_gnt && d_we;
        end
    end

    mcpu_ram_array #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_mem_rdata)
    );

    // Clear FSM: walk the whole array once, then run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state   <= S_RUN;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CW'(1);
                    end
                end
                S_RUN:   r_state <= S_RUN;
                default: r_state <= RST_STATE;
            endcase
        end
    end

    // Starvation counter: counts denied fetch cycles, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!i_req || i_gnt) begin
            r_starve <= '0;
        end else if (r_starve != STARVE_MAX) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // Read-response pipeline and last-value hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_rvalid <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_hold   <= '0;
            r_i_hold   <= '0;
        end else begin
            r_d_rvalid <= d_gnt && !d_we;
            r_i_rvalid <= i_gnt;
            if (w_d_rv) begin
                r_d_hold <= w_mem_rdata;
            end
            if (w_i_rv) begin
                r_i_hold <= w_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mcpu_ram_arbctrl.sv
// Directed self-checking bench for mcpu_ram_arbctrl (cleared and non-cleared builds).
module tb_mcpu_ram_arbctrl;

    logic        clk = 1'b0;
    logic        rst, d_req, d_we, i_req;
    logic [7:0]  d_addr, i_addr;
    logic [15:0] d_wdata, d_rdata, i_rdata;
    logic        d_gnt, d_rvalid, i_gnt, i_rvalid, busy;

    logic        n_rst, n_d_req, n_d_we, n_i_req;
    logic [7:0]  n_d_addr, n_i_addr;
    logic [15:0] n_d_wdata, n_d_rdata, n_i_rdata;
    logic        n_d_gnt, n_d_rvalid, n_i_gnt, n_i_rvalid, n_busy;

    int checks = 0;
    int failures = 0;
    logic [15:0] shadow [256];

    always #5 clk = ~clk;

    mcpu_ram_arbctrl #(.WORD_SIZE(16), .ADDR_WIDTH(8), .STARVE_LIMIT(4), .INIT_CLEAR(1)) u_dut (
        .clk(clk), .rst(rst), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .i_req(i_req), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .busy(busy)
    );

    mcpu_ram_arbctrl #(.WORD_SIZE(16), .ADDR_WIDTH(8), .STARVE_LIMIT(4), .INIT_CLEAR(0)) u_dut_nc (
        .clk(clk), .rst(n_rst), .d_req(n_d_req), .d_we(n_d_we), .d_addr(n_d_addr), .d_wdata(n_d_wdata),
        .d_gnt(n_d_gnt), .d_rvalid(n_d_rvalid), .d_rdata(n_d_rdata), .i_req(n_i_req), .i_addr(n_i_addr),
        .i_gnt(n_i_gnt), .i_rvalid(n_i_rvalid), .i_rdata(n_i_rdata), .busy(n_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold d_req (read) while busy; counts busy cycles, checks no grants meanwhile
    task automatic wait_clear(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            checks++;
            if (d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
                failures++;
                $display("FAIL clear_gnt cycle=%0d d_gnt=%b i_gnt=%b expected 0", n, d_gnt, i_gnt);
            end
            n++;
            step();
            #1;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;
        i_req = 1'b1; i_addr = 8'h00;
        step(); step(); #1;
        checks++;
        if (busy !== 1'b1 || d_gnt !== 1'b0 || i_gnt !== 1'b0 || d_rvalid !== 1'b0 ||
            i_rvalid !== 1'b0 || d_rdata !== 16'h0000 || i_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state busy=%b gnt=%b%b rvalid=%b%b rdata=%h/%h expected busy=1 rest 0",
                     busy, d_gnt, i_gnt, d_rvalid, i_rvalid, d_rdata, i_rdata);
        end
        i_req = 1'b0; rst = 1'b0; #1;
        wait_clear(n);
        checks++;
        if (n !== 256) begin
            failures++;
            $display("FAIL clear_len got=%0d expected=256", n);
        end
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL gnt_on_run_entry d_gnt=%b expected 1", d_gnt);
        end
        d_req = 1'b0;
        for (int a = 0; a < 256; a++) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = 8'(a); #1;
            checks++;
            if (d_gnt !== 1'b1) begin
                failures++;
                $display("FAIL clr_read_gnt addr=%0d d_gnt=%b expected 1", a, d_gnt);
            end
            step();
            d_req = 1'b0; #1;
            checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== 16'h0000) begin
                failures++;
                $display("FAIL clr_read addr=%0d rvalid=%b rdata=%h expected 1/0000", a, d_rvalid, d_rdata);
            end
            step();
        end
    endtask

    task automatic test_write_read_i();
        for (int a = 0; a < 256; a++) begin
            shadow[a] = 16'($urandom);
            d_req = 1'b1; d_we = 1'b1; d_addr = 8'(a); d_wdata = shadow[a]; #1;
            checks++;
            if (d_gnt !== 1'b1) begin
                failures++;
                $display("FAIL write_gnt addr=%0d d_gnt=%b expected 1", a, d_gnt);
            end
            step();
        end
        d_req = 1'b0; d_we = 1'b0; #1;
        checks++;
        if (d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL write_no_rvalid d_rvalid=%b expected 0", d_rvalid);
        end
        for (int a = 0; a < 256; a++) begin
            i_req = 1'b1; i_addr = 8'(a); #1;
            checks++;
            if (i_gnt !== 1'b1 || i_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL i_gnt addr=%0d i_gnt=%b i_rvalid=%b expected 1/0", a, i_gnt, i_rvalid);
            end
            step();
            i_req = 1'b0; #1;
            checks++;
            if (i_rvalid !== 1'b1 || i_rdata !== shadow[a] || d_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL i_read addr=%0d rvalid=%b rdata=%h expected 1/%h", a, i_rvalid, i_rdata, shadow[a]);
            end
            step();
        end
    endtask

    task automatic test_starve();
        logic exp_i;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01; i_req = 1'b1; i_addr = 8'h02;
        for (int k = 0; k < 20; k++) begin
            #1;
            exp_i = ((k % 5) == 4);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                failures++;
                $display("FAIL starve cycle=%0d d_gnt=%b i_gnt=%b expected %b/%b", k, d_gnt, i_gnt, !exp_i, exp_i);
            end
            step();
        end
        d_req = 1'b0; i_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'hBEEF; #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL raw_wr_gnt d_gnt=%b expected 1", d_gnt);
        end
        step();
        d_we = 1'b0; #1;
        checks++;
        if (d_gnt !== 1'b1 || d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL raw_rd_gnt d_gnt=%b d_rvalid=%b expected 1/0", d_gnt, d_rvalid);
        end
        step();
        d_req = 1'b0; #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL raw_data rvalid=%b rdata=%h expected 1/beef", d_rvalid, d_rdata);
        end
        step(); #1;
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL rdata_hold rvalid=%b rdata=%h expected 0/beef", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        rst = 1'b1; step(); step();
        rst = 1'b0;
        for (int k = 0; k < 128; k++) step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_clear_busy busy=%b expected 1", busy);
        end
        rst = 1'b1; step();
        rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; #1;
        wait_clear(n);
        checks++;
        if (n !== 256) begin
            failures++;
            $display("FAIL restart_clear_len got=%0d expected=256", n);
        end
        step();
        d_req = 1'b0; #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL recleared_data rvalid=%b rdata=%h expected 1/0000", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; #1;
        step();
        d_req = 1'b0; rst = 1'b1; #1;
        checks++;
        if (d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_read rvalid=%b expected 0", d_rvalid);
        end
        step(); #1;
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 16'h0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_read_after rvalid=%b rdata=%h busy=%b expected 0/0000/1", d_rvalid, d_rdata, busy);
        end
        rst = 1'b0; d_req = 1'b1; #1;
        wait_clear(n);
        checks++;
        if (n !== 256) begin
            failures++;
            $display("FAIL clear_after_read_rst got=%0d expected=256", n);
        end
        d_req = 1'b0;
    endtask

    task automatic test_no_clear();
        n_d_req = 1'b1; n_d_we = 1'b1; n_d_addr = 8'h05; n_d_wdata = 16'h1234;
        step(); step(); #1;
        checks++;
        if (n_busy !== 1'b0 || n_d_gnt !== 1'b0 || n_d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL nc_reset busy=%b gnt=%b rvalid=%b expected 0/0/0", n_busy, n_d_gnt, n_d_rvalid);
        end
        n_rst = 1'b0; #1;
        checks++;
        if (n_busy !== 1'b0 || n_d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL nc_immediate busy=%b d_gnt=%b expected 0/1", n_busy, n_d_gnt);
        end
        step();
        n_d_we = 1'b0; #1;
        checks++;
        if (n_d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL nc_read_gnt d_gnt=%b expected 1", n_d_gnt);
        end
        step();
        n_d_req = 1'b0; #1;
        checks++;
        if (n_d_rvalid !== 1'b1 || n_d_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL nc_read rvalid=%b rdata=%h expected 1/1234", n_d_rvalid, n_d_rdata);
        end
    endtask

    initial begin
        n_rst = 1'b1; n_d_req = 1'b0; n_d_we = 1'b0; n_d_addr = 8'h00; n_d_wdata = 16'h0000;
        n_i_req = 1'b0; n_i_addr = 8'h00;
        test_reset();
        test_write_read_i();
        test_starve();
        test_back_to_back();
        test_reset_mid_clear();
        test_reset_mid_read();
        test_no_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcpu_ram_arbctrl.md
# mcpu_ram_arbctrl

Parametrised single-port RAM controller that shares one synchronous memory array between the MCPU data port (read/write) and instruction-fetch port (read-only). Replaces the unclocked combinational RAM controller with a clocked, request/grant design:
- one-cycle read latency;
- fixed data-over-instruction priority with a starvation guard;
- optional hardware clear of the whole array after reset.

It sits between the MCPU core's load/store and fetch units and the on-chip RAM.

## Interface
Parameters:
- WORD_SIZE, 16, data/instruction word width in bits
- ADDR_WIDTH, 8, address width; depth RAM_SIZE = 2**ADDR_WIDTH
- STARVE_LIMIT, 4, consecutive denied instruction cycles before instruction port wins (must be ≥1)
- INIT_CLEAR, 1, 1 = zero whole array after reset; 0 = skip clear

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- d_req  in  1  data-port request
- d_we  in  1  1 = write, 0 = read; qualified by d_req
- d_addr  in  ADDR_WIDTH  data-port address
- d_wdata  in  WORD_SIZE  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid (one-cycle pulse)
- d_rdata  out  WORD_SIZE  data-port read data
- i_req  in  1  instruction-fetch request
- i_addr  in  ADDR_WIDTH  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  i_rdata valid (one-cycle pulse)
- i_rdata  out  WORD_SIZE  fetched word
- busy  out  1  array clear in progress; no grants

## Operation
- States: S_CLEAR, S_RUN.
- Reset → S_CLEAR if INIT_CLEAR = 1, else S_RUN.
- S_CLEAR:
  - clear counter walks 0 → RAM_SIZE-1, writing 0 each cycle;
  - busy = 1, both gnt = 0;
  - after writing RAM_SIZE-1 → S_RUN.
- S_RUN grants:
  - at most one access per cycle;
  - gnt is combinational from req and arbitration state;
  - a transfer happens on a rising edge where req && gnt.
- Arbitration, default: d_req wins.
- Arbitration, starvation guard:
  - i_req wins when starve_cnt == STARVE_LIMIT, or when d_req = 0;
  - starve_cnt increments when i_req && !i_gnt, saturating at STARVE_LIMIT;
  - starve_cnt clears when i_gnt, or when i_req = 0.
- Requests: requester holds req/addr/data until gnt. Dropping req before gnt is legal; no access occurs.
- Writes:
  - d_wdata stored at d_addr on the grant edge;
  - no d_rvalid for writes.
- Reads:
  - array read on the grant edge;
  - matching rvalid = 1 with rdata the following cycle;
  - rdata holds its last value when rvalid = 0.
- Read-after-write, same address, back-to-back: returns the new value. Single port, so this happens naturally.
- Widths: counters sized by ADDR_WIDTH+1 and $clog2(STARVE_LIMIT+1). No truncation of addresses.

## Timing
- Reset values:
  - d_gnt = i_gnt = 0;
  - d_rvalid = i_rvalid = 0;
  - d_rdata = i_rdata = 0;
  - starve_cnt = 0;
  - clear counter = 0;
  - busy = INIT_CLEAR.
- Clear duration: exactly RAM_SIZE cycles after rst deasserts. busy falls on the cycle S_RUN is entered; grants are possible that same cycle.
- Read latency: 1 cycle, grant edge → rvalid high.
- Throughput: 1 access per cycle total across both ports.
- Simultaneous d_req and i_req: data granted unless the starvation guard is active. The loser sees gnt = 0 and retries.
- Reset mid-clear: clear restarts at address 0.
- Reset mid-read: the pending rvalid is suppressed.
- Memory contents are not reset when INIT_CLEAR = 0.

## Structure
- Package mcpu_ram_pkg holds:
  - default WORD_SIZE / ADDR_WIDTH / STARVE_LIMIT constants;
  - state enum {S_CLEAR, S_RUN}.
- Sub-module mcpu_ram_array: single-port synchronous RAM (clk, we, addr, wdata, rdata, registered read). It is instantiated once.
- Controller holds the arbiter, starvation counter, clear FSM and rvalid pipeline.

## Test plan
- Reset with INIT_CLEAR = 1 → busy high for exactly 256 cycles, gnts 0 throughout; then read all 256 addresses via d port → every d_rdata = 0x0000.
- Write 256 random words via d port, then read each back via i port → i_rdata matches the shadow copy, i_rvalid exactly one cycle after each i_gnt.
- d_req held continuously with reads and i_req held → i_gnt asserted once every STARVE_LIMIT+1 = 5 cycles; d_gnt on the other 4.
- Write 0xBEEF to addr 0x10, then read 0x10 on the next cycle → d_rdata = 0xBEEF, d_rvalid on the following cycle.
- Assert rst at clear address 0x80 → clear restarts, busy lasts a further 256 cycles. Assert rst the cycle after a read grant → rvalid stays 0.
- INIT_CLEAR = 0, rst pulse → busy = 0 the cycle after reset; a d_req read is granted immediately.
